// File: rtl/freq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : freq_pkg                                                     |
// | Description : Shared definitions for the frequency-step controller and the |
// |               DDS tuning logic: FSM state encoding, native frequency-word  |
// |               width and the saturating add/sub helper.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package freq_pkg;

    // Native frequency-word width. Users of sat_step with a narrower word
    // zero-extend into this width and truncate the result back.
    localparam int unsigned c_FREQ_W = 32;

    // Key-handling FSM states
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_HOLD   = 2'd1;
    localparam logic [1:0] c_ST_REPEAT = 2'd2;
    localparam logic [1:0] c_ST_BOTH   = 2'd3;

    // Saturating step. The sum / bound is formed one bit wider than the word
    // so that cur+step can never wrap before it is compared with hi, and
    // lo+step can never wrap before it is compared with cur.
    function automatic logic [c_FREQ_W-1:0] sat_step(
        input logic [c_FREQ_W-1:0] cur,
        input logic [c_FREQ_W-1:0] step,
        input logic [c_FREQ_W-1:0] lo,
        input logic [c_FREQ_W-1:0] hi,
        input logic                up
    );
        logic [c_FREQ_W:0]   w_wide;
        logic [c_FREQ_W-1:0] w_res;
        if (up) begin
            w_wide = {1'b0, cur} + {1'b0, step};
            w_res  = (w_wide > {1'b0, hi}) ? hi : w_wide[c_FREQ_W-1:0];
        end else begin
            w_wide = {1'b0, lo} + {1'b0, step};
            w_res  = ({1'b0, cur} < w_wide) ? lo : (cur - step);
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_debounce                                                 |
// | Description : Two-flop synchroniser followed by a counting debouncer for   |
// |               one raw active-low push-button.                              |
// | Ports       : clk        - system clock                                    |
// |               rst        - synchronous active-high reset                   |
// |               i_key_n    - raw asynchronous key, low = pressed             |
// |               o_pressed  - debounced key state, high = pressed             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_pressed
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic               r_level;   // debounced raw level, 1 = released
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_key_n};
            // Count consecutive cycles of disagreement; any agreement restarts.
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign o_pressed = ~r_level;

endmodule
`default_nettype wire

// File: rtl/freq_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : freq_step_ctrl                                               |
// | Description : Two-key frequency selector. Debounced up/down keys step a    |
// |               saturating frequency word: single step on press, auto-repeat |
// |               on hold, coarse steps after sustained repeat, default value  |
// |               when both keys are pressed.                                  |
// | Ports       : clk_i           - system clock                               |
// |               rst_i           - synchronous active-high reset              |
// |               freq_up_key_i   - raw up key, active-low, asynchronous       |
// |               freq_down_key_i - raw down key, active-low, asynchronous     |
// |               frequency_o     - current frequency word                     |
// |               freq_upd_o      - one-cycle pulse when frequency_o changes   |
// |               at_limit_o      - frequency_o equals FREQ_MIN or FREQ_MAX    |
// |               fast_o          - coarse stepping active                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module freq_step_ctrl
    import freq_pkg::*;
#(
    parameter int FREQ_W          = c_FREQ_W,   // must not exceed c_FREQ_W
    parameter int FREQ_MIN        = 1,
    parameter int FREQ_MAX        = 10_000_000,
    parameter int FREQ_DEFAULT    = 1000,
    parameter int STEP_FINE       = 10,
    parameter int STEP_COARSE     = 1000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int REPEAT_CYCLES   = 5_000_000,
    parameter int ACCEL_REPEATS   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              freq_up_key_i,
    input  logic              freq_down_key_i,
    output logic [FREQ_W-1:0] frequency_o,
    output logic              freq_upd_o,
    output logic              at_limit_o,
    output logic              fast_o
);

    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int c_REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam int c_NREP_W = $clog2(ACCEL_REPEATS + 2);

    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_REP_W-1:0]  c_REP_LAST  = c_REP_W'(REPEAT_CYCLES - 1);
    localparam logic [c_NREP_W-1:0] c_NREP_ACC  = c_NREP_W'(ACCEL_REPEATS);
    localparam logic [c_NREP_W-1:0] c_NREP_SAT  = c_NREP_W'(ACCEL_REPEATS + 1);

    localparam logic [FREQ_W-1:0]   c_DEF_F = FREQ_W'(FREQ_DEFAULT);
    localparam logic [FREQ_W-1:0]   c_MIN_F = FREQ_W'(FREQ_MIN);
    localparam logic [FREQ_W-1:0]   c_MAX_F = FREQ_W'(FREQ_MAX);
    localparam logic [c_FREQ_W-1:0] c_MIN_X = c_FREQ_W'(FREQ_MIN);
    localparam logic [c_FREQ_W-1:0] c_MAX_X = c_FREQ_W'(FREQ_MAX);
    localparam logic [c_FREQ_W-1:0] c_FINE_X   = c_FREQ_W'(STEP_FINE);
    localparam logic [c_FREQ_W-1:0] c_COARSE_X = c_FREQ_W'(STEP_COARSE);

    logic w_up_pressed;
    logic w_dn_pressed;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_up_key (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_key_n   (freq_up_key_i),
        .o_pressed (w_up_pressed)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_dn_key (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_key_n   (freq_down_key_i),
        .o_pressed (w_dn_pressed)
    );

    logic [1:0]          r_state;
    logic                r_dir;        // 1 = stepping up
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_REP_W-1:0]  r_rep_cnt;
    logic [c_NREP_W-1:0] r_n_rep;      // auto-steps taken, saturates one past ACCEL_REPEATS
    logic [FREQ_W-1:0]   r_freq;
    logic                r_upd;

    logic [1:0]          w_state_nxt;
    logic                w_dir_nxt;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic [c_REP_W-1:0]  w_rep_nxt;
    logic [c_NREP_W-1:0] w_nrep_nxt;
    logic [FREQ_W-1:0]   w_freq_nxt;
    logic                w_do_step;
    logic                w_coarse;
    logic                w_dir_pressed;
    logic                w_opp_pressed;
    logic [c_FREQ_W-1:0] w_freq_ext;
    logic [c_FREQ_W-1:0] w_step_ext;

    assign w_dir_pressed = r_dir ? w_up_pressed : w_dn_pressed;
    assign w_opp_pressed = r_dir ? w_dn_pressed : w_up_pressed;
    assign w_freq_ext    = c_FREQ_W'(r_freq);
    assign w_step_ext    = w_coarse ? c_COARSE_X : c_FINE_X;

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_hold_nxt  = r_hold_cnt;
        w_rep_nxt   = r_rep_cnt;
        w_nrep_nxt  = r_n_rep;
        w_freq_nxt  = r_freq;
        w_do_step   = 1'b0;
        w_coarse    = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_hold_nxt = '0;
                w_rep_nxt  = '0;
                w_nrep_nxt = '0;
                if (w_up_pressed && w_dn_pressed) begin
                    w_freq_nxt  = c_DEF_F;
                    w_state_nxt = c_ST_BOTH;
                end else if (w_up_pressed || w_dn_pressed) begin
                    w_do_step   = 1'b1;
                    w_dir_nxt   = w_up_pressed;
                    w_state_nxt = c_ST_HOLD;
                end
            end

            c_ST_HOLD: begin
                // The opposite key wins over release so a roll-over from one
                // key to the other is treated as a both-key press.
                if (w_opp_pressed) begin
                    w_freq_nxt  = c_DEF_F;
                    w_state_nxt = c_ST_BOTH;
                end else if (!w_dir_pressed) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    w_do_step   = 1'b1;
                    w_state_nxt = c_ST_REPEAT;
                    w_rep_nxt   = '0;
                    w_nrep_nxt  = c_NREP_W'(1);
                end else begin
                    w_hold_nxt = r_hold_cnt + c_HOLD_W'(1);
                end
            end

            c_ST_REPEAT: begin
                if (w_opp_pressed) begin
                    w_freq_nxt  = c_DEF_F;
                    w_state_nxt = c_ST_BOTH;
                end else if (!w_dir_pressed) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_rep_cnt == c_REP_LAST) begin
                    w_do_step = 1'b1;
                    // This step is auto-step number r_n_rep+1; coarse once
                    // that number exceeds ACCEL_REPEATS.
                    w_coarse  = (r_n_rep >= c_NREP_ACC);
                    w_rep_nxt = '0;
                    if (r_n_rep != c_NREP_SAT) begin
                        w_nrep_nxt = r_n_rep + c_NREP_W'(1);
                    end
                end else begin
                    w_rep_nxt = r_rep_cnt + c_REP_W'(1);
                end
            end

            c_ST_BOTH: begin
                if (!w_up_pressed && !w_dn_pressed) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        if (w_do_step) begin
            w_freq_nxt = FREQ_W'(sat_step(w_freq_ext, w_step_ext, c_MIN_X, c_MAX_X, w_dir_nxt));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_ST_IDLE;
            r_dir      <= 1'b0;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_n_rep    <= '0;
            r_freq     <= c_DEF_F;
            r_upd      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dir      <= w_dir_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rep_cnt  <= w_rep_nxt;
            r_n_rep    <= w_nrep_nxt;
            r_freq     <= w_freq_nxt;
            // Pulse only on a real change: saturated steps and redundant
            // default loads stay silent.
            r_upd      <= (w_freq_nxt != r_freq);
        end
    end

    assign frequency_o = r_freq;
    assign freq_upd_o  = r_upd;
    assign at_limit_o  = (r_freq == c_MIN_F) || (r_freq == c_MAX_F);
    assign fast_o      = (r_state == c_ST_REPEAT) && (r_n_rep > c_NREP_ACC);

endmodule
`default_nettype wire

// File: tb/tb_freq_step_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_freq_step_ctrl                                            |
// | Description : Scoreboard bench for freq_step_ctrl. Stimulus pushes the     |
// |               expected frequency updates; a monitor pops one entry per     |
// |               freq_upd_o pulse and compares it.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_freq_step_ctrl;

    localparam int c_DEB    = 4;
    localparam int c_HOLD   = 50;
    localparam int c_REP    = 10;
    localparam int c_ACCEL  = 3;
    localparam int c_FINE   = 10;
    localparam int c_COARSE = 100;
    localparam int c_MIN    = 100;
    localparam int c_MAX    = 2000;
    localparam int c_DEF    = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up_key = 1'b1;
    logic        dn_key = 1'b1;
    logic [31:0] frequency;
    logic        freq_upd;
    logic        at_limit;
    logic        fast;

    freq_step_ctrl #(
        .FREQ_W          (32),
        .FREQ_MIN        (c_MIN),
        .FREQ_MAX        (c_MAX),
        .FREQ_DEFAULT    (c_DEF),
        .STEP_FINE       (c_FINE),
        .STEP_COARSE     (c_COARSE),
        .DEBOUNCE_CYCLES (c_DEB),
        .HOLD_CYCLES     (c_HOLD),
        .REPEAT_CYCLES   (c_REP),
        .ACCEL_REPEATS   (c_ACCEL)
    ) u_dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .freq_up_key_i   (up_key),
        .freq_down_key_i (dn_key),
        .frequency_o     (frequency),
        .freq_upd_o      (freq_upd),
        .at_limit_o      (at_limit),
        .fast_o          (fast)
    );

    always #5 clk = ~clk;

    typedef struct {
        int freq;
        bit fast;
        bit chk_lat;   // check press-to-update latency against t0
        int t0;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   m_freq = c_DEF;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int f, input int step, input bit up);
        if (up) return (f + step > c_MAX) ? c_MAX : f + step;
        return (f < c_MIN + step) ? c_MIN : f - step;
    endfunction

    // Record the model value; only a change of value produces an expected pulse.
    task automatic push(input int f, input bit fst, input bit lat, input int t0);
        exp_t e;
        if (f != m_freq) begin
            e.freq    = f;
            e.fast    = fst;
            e.chk_lat = lat;
            e.t0      = t0;
            sb_q.push_back(e);
        end
        m_freq = f;
    endtask

    // Step k=0 is the press step; k>=1 are auto-steps, coarse beyond c_ACCEL.
    task automatic expect_hold(input bit up, input int n_steps, input int t0);
        int step;
        for (int k = 0; k < n_steps; k++) begin
            step = (k <= c_ACCEL) ? c_FINE : c_COARSE;
            push(sat(m_freq, step, up), k > c_ACCEL, k == 0, t0);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 400) begin
            tick(1);
            n++;
        end
        chk(tag, sb_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        m_freq = c_DEF;
    endtask

    // Monitor: one scoreboard entry per update pulse.
    always @(negedge clk) begin
        if (!rst && freq_upd) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_update: frequency_o=%0d, no update expected", frequency);
            end else begin
                mon_e = sb_q.pop_front();
                chk("upd_frequency", frequency, mon_e.freq);
                chk("upd_fast", fast, mon_e.fast);
                chk("upd_at_limit", at_limit, (mon_e.freq == c_MIN || mon_e.freq == c_MAX) ? 1 : 0);
                if (mon_e.chk_lat) begin
                    n_checks++;
                    if (cyc - mon_e.t0 < 5 || cyc - mon_e.t0 > 7) begin
                        n_errors++;
                        $display("FAIL key_to_update_latency: got %0d cycles, expected 5..7", cyc - mon_e.t0);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached with %0d pending updates", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;

        // 1. reset state
        do_reset();
        chk("reset_frequency", frequency, c_DEF);
        chk("reset_upd", freq_upd, 0);
        chk("reset_at_limit", at_limit, 0);
        chk("reset_fast", fast, 0);

        // 2. single press, then a short glitch
        t0 = cyc;
        up_key = 1'b0;
        expect_hold(1'b1, 1, t0);                 // 1010
        tick(20);
        up_key = 1'b1;
        tick(20);
        drain("press_drained");
        up_key = 1'b0;
        tick(2);
        up_key = 1'b1;
        tick(20);
        chk("glitch_no_change", frequency, 1010);

        // 3. hold up: 1010, 1020, 1030, 1040, 1140, 1240 then release
        do_reset();
        t0 = cyc;
        up_key = 1'b0;
        expect_hold(1'b1, 6, t0);
        tick(95);
        up_key = 1'b1;
        tick(5);
        chk("fast_before_release", fast, 1);
        tick(10);
        chk("fast_after_release", fast, 0);
        drain("hold_drained");
        chk("hold_final", frequency, 1240);

        // 4a. clamp up: coarse run saturates at 2000 with two silent steps
        do_reset();
        t0 = cyc;
        up_key = 1'b0;
        expect_hold(1'b1, 16, t0);
        tick(195);
        up_key = 1'b1;
        tick(15);
        drain("clamp_up_drained");
        chk("clamp_up_value", frequency, c_MAX);
        t0 = cyc;
        dn_key = 1'b0;
        expect_hold(1'b0, 1, t0);                 // 1990
        tick(20);
        dn_key = 1'b1;
        tick(15);
        drain("step_down_drained");
        t0 = cyc;
        up_key = 1'b0;
        expect_hold(1'b1, 4, t0);                 // 2000, then three silent steps
        tick(75);
        up_key = 1'b1;
        tick(15);
        drain("reclamp_drained");
        chk("reclamp_at_limit", at_limit, 1);

        // 4b. clamp down: 990, then hold down to 150 (coarse) and 100
        do_reset();
        t0 = cyc;
        dn_key = 1'b0;
        expect_hold(1'b0, 1, t0);
        tick(20);
        dn_key = 1'b1;
        tick(15);
        drain("pre_down_drained");
        t0 = cyc;
        dn_key = 1'b0;
        expect_hold(1'b0, 14, t0);
        tick(175);
        dn_key = 1'b1;
        tick(15);
        drain("clamp_down_drained");
        chk("clamp_down_value", frequency, c_MIN);
        chk("clamp_down_at_limit", at_limit, 1);

        // 5. both keys during REPEAT
        do_reset();
        t0 = cyc;
        up_key = 1'b0;
        expect_hold(1'b1, 4, t0);                 // up to 1040
        tick(72);
        t0 = cyc;
        dn_key = 1'b0;
        push(c_DEF, 1'b0, 1'b1, t0);
        tick(30);
        up_key = 1'b1;                            // down still held
        tick(40);
        chk("both_hold_value", frequency, c_DEF);
        dn_key = 1'b1;
        tick(20);
        drain("both_drained");
        chk("both_release_value", frequency, c_DEF);
        t0 = cyc;
        up_key = 1'b0;
        expect_hold(1'b1, 1, t0);                 // 1010
        tick(20);
        up_key = 1'b1;
        tick(15);
        drain("after_both_drained");

        // 6. reset mid-REPEAT at 1240 with the key still held
        do_reset();
        t0 = cyc;
        up_key = 1'b0;
        expect_hold(1'b1, 6, t0);
        tick(100);
        chk("pre_reset_value", frequency, 1240);
        chk("pre_reset_drained", sb_q.size(), 0);
        rst = 1'b1;
        tick(1);
        chk("mid_reset_frequency", frequency, c_DEF);
        chk("mid_reset_fast", fast, 0);
        chk("mid_reset_upd", freq_upd, 0);
        rst = 1'b0;
        m_freq = c_DEF;
        t0 = cyc;
        expect_hold(1'b1, 1, t0);                 // held key is a new press
        tick(20);
        up_key = 1'b1;
        tick(15);
        drain("post_reset_drained");
        chk("post_reset_value", frequency, 1010);

        tick(10);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
